perm_rot_pipe: RTL

Parametrised, pipelined lane-rotation permuter for the FFT datapath. It reorders LANES complex words between butterfly stages.
- Lane i of the output takes input lane (i+s) mod LANES, or (i−s) mod LANES in inverse mode.
- The rotation s comes either from an external SEL or from an internal per-beat counter for automatic stride rotation.
- One registered stage with valid/ready handshake, so it sits between memory-read and butterfly pipelines without stalling upstream.

---
 rtl/perm_rot_pipe.sv | 90 +++++++++
 1 files changed

// File: rtl/perm_rot_pipe.sv
// perm_rot_pipe
//   Registered lane-rotation permuter for the FFT datapath. Reorders LANES
//   complex words between butterfly stages, with one valid/ready stage.
//   Forward (DIR=0): Q[i] = D[(i+s) mod LANES]
//   Inverse (DIR=1): Q[i] = D[(i-s) mod LANES]
//   s is SEL in manual mode, or an internal per-beat counter in auto mode.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   MODE       0 = manual (s = SEL), 1 = auto (s = internal counter)
//   SEL        rotation amount in manual mode, sampled with the accepted beat
//   CLR        auto-counter clear, effective in the same cycle
//   IN_VALID   input beat valid
//   IN_READY   block can accept a beat
//   D          input lanes, lane i = D[i*W +: W]
//   OUT_VALID  Q holds a valid beat
//   OUT_READY  downstream accepts the beat
//   Q          permuted lanes, lane i = Q[i*W +: W]
//   OUT_SEL    rotation applied to the beat on Q
module perm_rot_pipe #(
  parameter int LANES = 4,
  parameter int W     = 64,
  parameter int SW    = $clog2(LANES),
  parameter int DIR   = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               MODE,
  input  logic [SW-1:0]      SEL,
  input  logic               CLR,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [LANES*W-1:0] D,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [LANES*W-1:0] Q,
  output logic [SW-1:0]      OUT_SEL
);

  logic [SW-1:0]      cnt;
  logic [SW-1:0]      s_eff;
  logic [LANES*W-1:0] rot;
  logic               accept;
  logic               emit;

  // RST gates IN_READY so no beat is taken in the reset cycle.
  assign IN_READY = !RST && (!OUT_VALID || OUT_READY);
  assign accept   = IN_VALID && IN_READY;
  assign emit     = OUT_VALID && OUT_READY;

  // CLR forces s to zero for a beat accepted in the same cycle.
  assign s_eff = MODE ? (CLR ? '0 : cnt) : SEL;

  // LANES is a power of two, so SW-bit arithmetic wraps modulo LANES.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SW-1:0] src;
    if (DIR != 0) begin : g_inv
      assign src = SW'(i) - s_eff;
    end else begin : g_fwd
      assign src = SW'(i) + s_eff;
    end
    assign rot[i*W +: W] = D[src*W +: W];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (accept && MODE) begin
      cnt <= s_eff + SW'(1);
    end else if (CLR) begin
      cnt <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      Q         <= '0;
      OUT_SEL   <= '0;
    end else if (accept) begin
      OUT_VALID <= 1'b1;
      Q         <= rot;
      OUT_SEL   <= s_eff;
    end else if (emit) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule
